// File: rtl/reg_xfer_pkg.sv
// reg_xfer_pkg: state type, default width and parity helper shared by the serial transmitter and receiver.
package reg_xfer_pkg;
   typedef enum logic {IDLE, SHIFT} state_t;
   localparam int DEFAULT_WIDTH = 3;
   localparam int PARITY_MAX_W = 64;
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
      return ^v;
   endfunction
endpackage

// File: rtl/reg_serial_tx_if.sv
// reg_serial_tx_if: parallel load handshake and serial output bundle of the transmitter.
interface reg_serial_tx_if #(parameter int WIDTH = 3);
   logic [WIDTH-1:0] D;
   logic Load;
   logic Ready;
   logic SOut;
   logic SValid;
   logic Done;
   modport master(output D, Load, input Ready, SOut, SValid, Done);
   modport slave(input D, Load, output Ready, SOut, SValid, Done);
endinterface

// File: rtl/reg_xfer_shifter.sv
// reg_xfer_shifter: loadable shift register exposing its head bit, direction set by MSB_FIRST.
module reg_xfer_shifter #(
   parameter int WIDTH = 3,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] d,
   output logic             head
);
   logic [WIDTH-1:0] sr_q, sr_d;
   always_comb begin
      sr_d = load ? d : shift_en ? (MSB_FIRST ? sr_q << 1 : sr_q >> 1) : sr_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end
   assign head = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
endmodule

// File: rtl/reg_serial_tx.sv
// reg_serial_tx: captures D on Load when idle and sends it one bit per CLK with SValid framing and a Done pulse.
// Define REG_SERIAL_TX_PARITY_EN to append an even-parity bit to each frame.
module reg_serial_tx
   import reg_xfer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic CLK,
   input logic RST,
   reg_serial_tx_if.slave bus
);
`ifdef REG_SERIAL_TX_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 2);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic head, load, last;
   assign load = (state_q == IDLE) && bus.Load;
   always_comb begin
      last = (state_q == SHIFT) && (cnt_q == CW'(FLEN - 1));
      state_d = load ? SHIFT : last ? IDLE : state_q;
      cnt_d = load ? '0 : (state_q == SHIFT) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   reg_xfer_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shifter (
      .clk(CLK),
      .rst(RST),
      .load(load),
      .shift_en(state_q == SHIFT),
      .d(bus.D),
      .head(head)
   );
`ifdef REG_SERIAL_TX_PARITY_EN
   // parity is latched with the word so later D changes cannot affect it
   logic par_q, par_d;
   always_comb begin
      par_d = load ? even_parity(PARITY_MAX_W'(bus.D)) : par_q;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) par_q <= 1'b0;
      else     par_q <= par_d;
   end
   assign bus.SOut = (state_q == SHIFT) && (cnt_q < CW'(WIDTH) ? head : par_q);
`else
   assign bus.SOut = (state_q == SHIFT) && head;
`endif
   assign bus.Ready  = state_q == IDLE;
   assign bus.SValid = state_q == SHIFT;
   assign bus.Done   = last;
endmodule
